// File: rtl/vga_box_pixel_gen_if.sv
// Pixel-generator bus: timing-generator inputs plus pixel/status outputs.
//   master : timing-generator side; drives disp_ena/col/row/freeze and observes the results
//   slave  : pixel-generator side; consumes timing and drives pix_valid/pix_rgb/frame_cnt/box_x/box_y
interface vga_box_pixel_gen_if #(
    parameter int unsigned H_BITS = 7,
    parameter int unsigned V_BITS = 5
);
    logic              disp_ena;
    logic [H_BITS-1:0] col;
    logic [V_BITS-1:0] row;
    logic              freeze;
    logic              pix_valid;
    logic [11:0]       pix_rgb;
    logic [7:0]        frame_cnt;
    logic [H_BITS-1:0] box_x;
    logic [V_BITS-1:0] box_y;

    modport master (
        output disp_ena, col, row, freeze,
        input  pix_valid, pix_rgb, frame_cnt, box_x, box_y
    );

    modport slave (
        input  disp_ena, col, row, freeze,
        output pix_valid, pix_rgb, frame_cnt, box_x, box_y
    );
endinterface

// File: rtl/vga_box_pixel_gen.sv
// Bouncing-box pixel generator sitting after the VGA timing generator.
// Draws a BOX_W x BOX_H box over a background with a fixed 2-cycle latency from
// disp_ena/col/row to pix_valid/pix_rgb. The box moves one pixel per frame per axis
// and bounces off the visible-area edges; moves happen only in blanking.
// Ports:
//   clk    pixel clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of vga_box_pixel_gen_if (disp_ena, col, row, freeze in;
//          pix_valid, pix_rgb, frame_cnt, box_x, box_y out)
// Build option: define CHECKER_BG_EN for an 8x8 black/white checkerboard background
// instead of the solid BG_RGB colour.
module vga_box_pixel_gen #(
    parameter int unsigned H_BITS   = 7,
    parameter int unsigned V_BITS   = 5,
    parameter int unsigned H_PIXELS = 50,
    parameter int unsigned V_PIXELS = 25,
    parameter int unsigned BOX_W    = 8,
    parameter int unsigned BOX_H    = 4,
    parameter logic [11:0] BOX_RGB  = 12'hF00,
    parameter logic [11:0] BG_RGB   = 12'h00F
) (
    input  logic                clk,
    input  logic                rst_n,
    vga_box_pixel_gen_if.slave  bus
);
    localparam int unsigned HW    = H_BITS + 1;
    localparam int unsigned VW    = V_BITS + 1;
    localparam int unsigned X_MAX = H_PIXELS - BOX_W;
    localparam int unsigned Y_MAX = V_PIXELS - BOX_H;

    logic              s1_ena;
    logic              s1_in_box;
    logic              pix_valid;
    logic [11:0]       pix_rgb;
    logic [7:0]        frame_cnt;
    logic [H_BITS-1:0] box_x;
    logic [V_BITS-1:0] box_y;
    logic              dir_left;   // 0 = moving right (reset direction)
    logic              dir_up;     // 0 = moving down (reset direction)

    logic              in_box_c;
    logic              frame_end_c;
    logic [11:0]       bg_c;
    logic [H_BITS-1:0] next_x_c;
    logic [V_BITS-1:0] next_y_c;
    logic              next_left_c;
    logic              next_up_c;

    // Box hit test; one extra bit keeps box+size from wrapping.
    always_comb begin
        in_box_c = (HW'(bus.col) >= HW'(box_x)) &&
                   (HW'(bus.col) <  HW'(box_x) + HW'(BOX_W)) &&
                   (VW'(bus.row) >= VW'(box_y)) &&
                   (VW'(bus.row) <  VW'(box_y) + VW'(BOX_H));
    end

    // First blank cycle after the last visible pixel of the last row.
    assign frame_end_c = s1_ena && !bus.disp_ena && (bus.row == V_BITS'(V_PIXELS - 1));

`ifdef CHECKER_BG_EN
    logic s1_col2;
    logic s1_row2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_col2 <= 1'b0;
            s1_row2 <= 1'b0;
        end else begin
            s1_col2 <= bus.col[2];
            s1_row2 <= bus.row[2];
        end
    end

    assign bg_c = (s1_col2 ^ s1_row2) ? 12'hFFF : 12'h000;
`else
    assign bg_c = BG_RGB;
`endif

    // Next box position/direction; an axis with no travel room stays at 0.
    always_comb begin
        next_x_c    = box_x;
        next_left_c = dir_left;
        if (X_MAX != 0) begin
            if (!dir_left) begin
                if (box_x == H_BITS'(X_MAX)) begin
                    next_left_c = 1'b1;
                    next_x_c    = box_x - H_BITS'(1);
                end else begin
                    next_x_c    = box_x + H_BITS'(1);
                end
            end else begin
                if (box_x == '0) begin
                    next_left_c = 1'b0;
                    next_x_c    = box_x + H_BITS'(1);
                end else begin
                    next_x_c    = box_x - H_BITS'(1);
                end
            end
        end
    end

    always_comb begin
        next_y_c  = box_y;
        next_up_c = dir_up;
        if (Y_MAX != 0) begin
            if (!dir_up) begin
                if (box_y == V_BITS'(Y_MAX)) begin
                    next_up_c = 1'b1;
                    next_y_c  = box_y - V_BITS'(1);
                end else begin
                    next_y_c  = box_y + V_BITS'(1);
                end
            end else begin
                if (box_y == '0) begin
                    next_up_c = 1'b0;
                    next_y_c  = box_y + V_BITS'(1);
                end else begin
                    next_y_c  = box_y - V_BITS'(1);
                end
            end
        end
    end

    // Two-stage pixel pipeline plus per-frame box motion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ena    <= 1'b0;
            s1_in_box <= 1'b0;
            pix_valid <= 1'b0;
            pix_rgb   <= '0;
            frame_cnt <= '0;
            box_x     <= '0;
            box_y     <= '0;
            dir_left  <= 1'b0;
            dir_up    <= 1'b0;
        end else begin
            s1_ena    <= bus.disp_ena;
            s1_in_box <= in_box_c;
            pix_valid <= s1_ena;
            pix_rgb   <= !s1_ena ? 12'h000 : (s1_in_box ? BOX_RGB : bg_c);
            if (frame_end_c) begin
                frame_cnt <= frame_cnt + 8'd1;
                if (!bus.freeze) begin
                    box_x    <= next_x_c;
                    box_y    <= next_y_c;
                    dir_left <= next_left_c;
                    dir_up   <= next_up_c;
                end
            end
        end
    end

    assign bus.pix_valid = pix_valid;
    assign bus.pix_rgb   = pix_rgb;
    assign bus.frame_cnt = frame_cnt;
    assign bus.box_x     = box_x;
    assign bus.box_y     = box_y;
endmodule

// File: tb/tb_vga_box_pixel_gen.sv
// Self-checking bench for vga_box_pixel_gen (default parameters).
module tb_vga_box_pixel_gen;
    localparam int unsigned H_BITS = 7;
    localparam int unsigned V_BITS = 5;

    typedef struct {
        logic              ena;
        logic [H_BITS-1:0] col;
        logic [V_BITS-1:0] row;
        logic              exp_v;
        logic [11:0]       rgb_def;
        logic [11:0]       rgb_chk;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // reference bounce model for long frame runs
    int   mx, my, mcnt;
    bit   mleft, mup;

    vec_t t0 [9];
    vec_t t1 [8];

    vga_box_pixel_gen_if #(.H_BITS(H_BITS), .V_BITS(V_BITS)) bus ();

    vga_box_pixel_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_frame();
        if (!bus.freeze) begin
            if (!mleft) begin
                if (mx == 42) begin mleft = 1; mx = mx - 1; end else mx = mx + 1;
            end else begin
                if (mx == 0) begin mleft = 0; mx = mx + 1; end else mx = mx - 1;
            end
            if (!mup) begin
                if (my == 21) begin mup = 1; my = my - 1; end else my = my + 1;
            end else begin
                if (my == 0) begin mup = 0; my = my + 1; end else my = my - 1;
            end
        end
        mcnt = (mcnt + 1) % 256;
    endtask

    // Shortest legal frame: one visible pixel on the last row, then blank.
    task automatic quick_frame();
        @(negedge clk);
        bus.disp_ena = 1'b1; bus.row = 5'd24; bus.col = 7'd0;
        @(negedge clk);
        bus.disp_ena = 1'b0;
        @(negedge clk);
        model_frame();
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        logic [11:0] exp_rgb;
`ifdef CHECKER_BG_EN
        exp_rgb = v.rgb_chk;
`else
        exp_rgb = v.rgb_def;
`endif
        @(negedge clk);
        bus.disp_ena = v.ena; bus.col = v.col; bus.row = v.row;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, 32'(bus.pix_valid), 32'(v.exp_v));
        chk({name, "_rgb"}, 32'(bus.pix_rgb), 32'(exp_rgb));
    endtask

    initial begin
        total = 0; bad = 0;
        mx = 0; my = 0; mcnt = 0; mleft = 0; mup = 0;

        // box at (0,0): cols 0..7, rows 0..3
        t0[0] = '{1'b1, 7'd0,  5'd0,  1'b1, 12'hF00, 12'hF00};
        t0[1] = '{1'b1, 7'd10, 5'd0,  1'b1, 12'h00F, 12'h000};
        t0[2] = '{1'b1, 7'd7,  5'd3,  1'b1, 12'hF00, 12'hF00};
        t0[3] = '{1'b1, 7'd8,  5'd3,  1'b1, 12'h00F, 12'h000};
        t0[4] = '{1'b1, 7'd7,  5'd4,  1'b1, 12'h00F, 12'h000};
        t0[5] = '{1'b1, 7'd0,  5'd4,  1'b1, 12'h00F, 12'hFFF};
        t0[6] = '{1'b0, 7'd3,  5'd1,  1'b0, 12'h000, 12'h000};
        t0[7] = '{1'b1, 7'd49, 5'd23, 1'b1, 12'h00F, 12'hFFF};
        t0[8] = '{1'b1, 7'd12, 5'd0,  1'b1, 12'h00F, 12'hFFF};
        // box at (41,1): cols 41..48, rows 1..4
        t1[0] = '{1'b1, 7'd41, 5'd1,  1'b1, 12'hF00, 12'hF00};
        t1[1] = '{1'b1, 7'd40, 5'd1,  1'b1, 12'h00F, 12'h000};
        t1[2] = '{1'b1, 7'd48, 5'd4,  1'b1, 12'hF00, 12'hF00};
        t1[3] = '{1'b1, 7'd49, 5'd4,  1'b1, 12'h00F, 12'hFFF};
        t1[4] = '{1'b1, 7'd48, 5'd5,  1'b1, 12'h00F, 12'hFFF};
        t1[5] = '{1'b1, 7'd41, 5'd0,  1'b1, 12'h00F, 12'h000};
        t1[6] = '{1'b1, 7'd4,  5'd0,  1'b1, 12'h00F, 12'hFFF};
        t1[7] = '{1'b1, 7'd4,  5'd4,  1'b1, 12'h00F, 12'h000};

        // reset state
        rst_n = 1'b0;
        bus.disp_ena = 1'b0; bus.col = '0; bus.row = '0; bus.freeze = 1'b0;
        #12;
        chk("rst_valid", 32'(bus.pix_valid), 32'd0);
        chk("rst_rgb",   32'(bus.pix_rgb),   32'd0);
        chk("rst_cnt",   32'(bus.frame_cnt), 32'd0);
        chk("rst_x",     32'(bus.box_x),     32'd0);
        chk("rst_y",     32'(bus.box_y),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) apply_vec(t0[i], $sformatf("v0_%0d", i));

        // one full frame with horizontal and vertical blanking
        @(negedge clk);
        bus.disp_ena = 1'b0; bus.col = '0; bus.row = '0;
        for (int r = 0; r < 25; r++) begin
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (r == 24 && c == 50) begin
                    chk("frame_last_pix_x",   32'(bus.box_x),     32'd0);
                    chk("frame_last_pix_cnt", 32'(bus.frame_cnt), 32'd0);
                end
                bus.disp_ena = (c < 50);
                bus.col      = (c < 50) ? 7'(c) : 7'd49;
                bus.row      = 5'(r);
            end
        end
        for (int c = 0; c < 120; c++) @(negedge clk);
        model_frame();
        chk("frame1_cnt", 32'(bus.frame_cnt), 32'd1);
        chk("frame1_x",   32'(bus.box_x),     32'd1);
        chk("frame1_y",   32'(bus.box_y),     32'd1);

        // run to the bounce points
        for (int f = 2; f <= 43; f++) begin
            quick_frame();
            if (f == 21) chk("f21_y", 32'(bus.box_y), 32'd21);
            if (f == 22) chk("f22_y", 32'(bus.box_y), 32'd20);
            if (f == 42) begin
                chk("f42_x", 32'(bus.box_x), 32'd42);
                chk("f42_y", 32'(bus.box_y), 32'd0);
            end
            if (f == 43) begin
                chk("f43_x",   32'(bus.box_x),     32'd41);
                chk("f43_y",   32'(bus.box_y),     32'd1);
                chk("f43_cnt", 32'(bus.frame_cnt), 32'd43);
            end
        end

        for (int i = 0; i < 8; i++) apply_vec(t1[i], $sformatf("v1_%0d", i));
        @(negedge clk);
        bus.disp_ena = 1'b0; bus.row = 5'd1;

        // freeze holds position and direction, counter still runs
        bus.freeze = 1'b1;
        for (int f = 0; f < 3; f++) quick_frame();
        chk("frz_x",   32'(bus.box_x),     32'd41);
        chk("frz_y",   32'(bus.box_y),     32'd1);
        chk("frz_cnt", 32'(bus.frame_cnt), 32'd46);
        bus.freeze = 1'b0;
        quick_frame();
        chk("unfrz_x",   32'(bus.box_x),     32'd40);
        chk("unfrz_y",   32'(bus.box_y),     32'd2);
        chk("unfrz_cnt", 32'(bus.frame_cnt), 32'd47);

        // counter wrap at 256 frames
        for (int f = 47; f < 255; f++) quick_frame();
        chk("cnt_255", 32'(bus.frame_cnt), 32'd255);
        quick_frame();
        chk("cnt_wrap",  32'(bus.frame_cnt), 32'd0);
        chk("wrap_x",    32'(bus.box_x),     32'(mx));
        chk("wrap_y",    32'(bus.box_y),     32'(my));
        chk("wrap_mcnt", 32'(bus.frame_cnt), 32'(mcnt));

        // asynchronous reset mid-row
        @(negedge clk);
        bus.disp_ena = 1'b1; bus.col = 7'd0; bus.row = 5'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(bus.pix_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.pix_valid), 32'd0);
        chk("mid_rst_rgb",   32'(bus.pix_rgb),   32'd0);
        chk("mid_rst_x",     32'(bus.box_x),     32'd0);
        chk("mid_rst_y",     32'(bus.box_y),     32'd0);
        chk("mid_rst_cnt",   32'(bus.frame_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_1cyc_valid", 32'(bus.pix_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("rel_2cyc_valid", 32'(bus.pix_valid), 32'd1);
        chk("rel_2cyc_rgb",   32'(bus.pix_rgb),   32'h0F00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
